// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: circular buffer with first-word-fall-through
// read port, occupancy count, full/empty status and a sticky overrun flag.
module uart_rx_fifo #(
   parameter int unsigned DataBits  = 8,
   parameter int unsigned DepthLog2 = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rx_ready_i,
   input  logic [DataBits-1:0]  rx_data_i,
   input  logic                 read_en_i,
   input  logic                 clear_overrun_i,
   output logic [DataBits-1:0]  read_data_o,
   output logic                 empty_o,
   output logic                 full_o,
   output logic [DepthLog2:0]   count_o,
   output logic                 overrun_o
);

   localparam int unsigned Depth = 1 << DepthLog2;

   logic [DataBits-1:0]  mem_q [Depth];
   logic [DepthLog2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DepthLog2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DepthLog2:0]   count_q, count_d;
   logic                 overrun_q, overrun_d;

   logic rd_acc, wr_acc, wr_drop;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == (DepthLog2 + 1)'(Depth));
   assign count_o   = count_q;
   assign overrun_o = overrun_q;

   // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
   assign rd_acc  = read_en_i & ~empty_o;
   assign wr_acc  = rx_ready_i & (~full_o | rd_acc);
   assign wr_drop = rx_ready_i & ~wr_acc;

   assign read_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      overrun_d = overrun_q;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + DepthLog2'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + DepthLog2'(1);
      end

      if (wr_acc && !rd_acc) begin
         count_d = count_q + (DepthLog2 + 1)'(1);
      end else if (rd_acc && !wr_acc) begin
         count_d = count_q - (DepthLog2 + 1)'(1);
      end

      // A drop wins over a simultaneous clear.
      if (wr_drop) begin
         overrun_d = 1'b1;
      end else if (clear_overrun_i) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   // Storage is not reset; stored bytes are discarded by clearing the pointers and count.
   always_ff @(posedge clk_i) begin
      if (rst_ni && wr_acc) begin
         mem_q[wr_ptr_q] <= rx_data_i;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_uart_rx_fifo;

   localparam int Depth = 16;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       rx_ready_i;
   logic [7:0] rx_data_i;
   logic       read_en_i;
   logic       clear_overrun_i;
   logic [7:0] read_data_o;
   logic       empty_o;
   logic       full_o;
   logic [4:0] count_o;
   logic       overrun_o;

   int total = 0;
   int bad   = 0;

   logic [7:0] mq [$];
   bit         m_ovr = 1'b0;

   uart_rx_fifo #(
      .DataBits  (8),
      .DepthLog2 (4)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .rx_ready_i      (rx_ready_i),
      .rx_data_i       (rx_data_i),
      .read_en_i       (read_en_i),
      .clear_overrun_i (clear_overrun_i),
      .read_data_o     (read_data_o),
      .empty_o         (empty_o),
      .full_o          (full_o),
      .count_o         (count_o),
      .overrun_o       (overrun_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic       rn;
      logic       rdy;
      logic [7:0] data;
      logic       ren;
      logic       clr;
      int         e_count;
      logic       e_empty;
      logic       e_full;
      logic       e_ovr;
      logic [7:0] e_rd;
   } vec_t;

   task automatic expect_eq(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a byte queue of bounded length plus a sticky flag.
   task automatic model_edge(input logic rn, input logic rdy, input logic [7:0] d,
                             input logic ren, input logic clr);
      bit do_rd, do_wr;
      if (!rn) begin
         mq.delete();
         m_ovr = 1'b0;
      end else begin
         do_rd = ren && (mq.size() > 0);
         do_wr = rdy && ((mq.size() < Depth) || do_rd);
         if (do_rd) void'(mq.pop_front());
         if (do_wr) mq.push_back(d);
         if (rdy && !do_wr) m_ovr = 1'b1;
         else if (clr) m_ovr = 1'b0;
      end
   endtask

   task automatic drive(input logic rn, input logic rdy, input logic [7:0] d,
                        input logic ren, input logic clr);
      rst_ni = rn; rx_ready_i = rdy; rx_data_i = d; read_en_i = ren; clear_overrun_i = clr;
      @(posedge clk_i);
      model_edge(rn, rdy, d, ren, clr);
      #1;
   endtask

   task automatic check_model(input string tag);
      expect_eq({tag, ".count"}, int'(count_o), mq.size());
      expect_eq({tag, ".empty"}, int'(empty_o), int'(mq.size() == 0));
      expect_eq({tag, ".full"}, int'(full_o), int'(mq.size() == Depth));
      expect_eq({tag, ".rdata"}, int'(read_data_o), (mq.size() > 0) ? int'(mq[0]) : 0);
      expect_eq({tag, ".ovr"}, int'(overrun_o), int'(m_ovr));
   endtask

   task automatic step(input string tag, input logic rn, input logic rdy,
                       input logic [7:0] d, input logic ren, input logic clr);
      drive(rn, rdy, d, ren, clr);
      check_model(tag);
   endtask

   task automatic idle();
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   vec_t vecs [8];

   initial begin
      int nxt;
      rst_ni = 1'b0; rx_ready_i = 1'b0; rx_data_i = 8'h00; read_en_i = 1'b0;
      clear_overrun_i = 1'b0;

      //           rn    rdy   data   ren   clr   cnt empty full  ovr   rdata
      vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[1] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h55};
      vecs[2] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[3] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[4] = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h3C};
      vecs[5] = '{1'b1, 1'b1, 8'h7E, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h7E};
      vecs[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 8'h7E};
      vecs[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};

      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].rn, vecs[i].rdy, vecs[i].data, vecs[i].ren, vecs[i].clr);
         expect_eq($sformatf("vec%0d.count", i), int'(count_o), vecs[i].e_count);
         expect_eq($sformatf("vec%0d.empty", i), int'(empty_o), int'(vecs[i].e_empty));
         expect_eq($sformatf("vec%0d.full", i), int'(full_o), int'(vecs[i].e_full));
         expect_eq($sformatf("vec%0d.ovr", i), int'(overrun_o), int'(vecs[i].e_ovr));
         expect_eq($sformatf("vec%0d.rdata", i), int'(read_data_o), int'(vecs[i].e_rd));
      end

      // Fill 0x00..0x0F, overflow with 0xAA, drain in order.
      for (int i = 0; i < 16; i++) step("fill", 1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
      expect_eq("fill16.full", int'(full_o), 1);
      expect_eq("fill16.count", int'(count_o), 16);
      step("drop", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
      expect_eq("drop.ovr", int'(overrun_o), 1);
      expect_eq("drop.count", int'(count_o), 16);
      for (int i = 0; i < 16; i++) begin
         expect_eq("drain.order", int'(read_data_o), i);
         step("drain", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      end
      expect_eq("drain.empty", int'(empty_o), 1);
      step("clr", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      expect_eq("clr.ovr", int'(overrun_o), 0);

      // Simultaneous write and read while full.
      for (int i = 0; i < 16; i++) step("fill2", 1'b1, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      step("fullrw", 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0);
      expect_eq("fullrw.count", int'(count_o), 16);
      expect_eq("fullrw.ovr", int'(overrun_o), 0);
      for (int i = 0; i < 16; i++) begin
         expect_eq("fullrw.order", int'(read_data_o), (i < 15) ? (8'h11 + i) : 8'hC3);
         step("drain2", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      end

      // Drop wins over clear in the same cycle.
      for (int i = 0; i < 16; i++) step("fill3", 1'b1, 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      step("drop2", 1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
      step("dropclr", 1'b1, 1'b1, 8'hEF, 1'b0, 1'b1);
      expect_eq("dropclr.ovr", int'(overrun_o), 1);
      step("clronly", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      expect_eq("clronly.ovr", int'(overrun_o), 0);

      // Reset mid-stream with a write in the reset cycle.
      step("pre", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step("load5", 1'b1, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      step("rstwr", 1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
      expect_eq("rstwr.count", int'(count_o), 0);
      expect_eq("rstwr.empty", int'(empty_o), 1);
      expect_eq("rstwr.ovr", int'(overrun_o), 0);
      step("postrst", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      expect_eq("postrst.count", int'(count_o), 0);

      // 40-byte stream with interleaved reads: pointers wrap twice.
      nxt = 0;
      for (int i = 0; i < 40; i++) begin
         if (i >= 3 && !empty_o) begin
            expect_eq("stream.order", int'(read_data_o), 8'h40 + nxt);
            nxt++;
         end
         step("stream", 1'b1, 1'b1, 8'(8'h40 + i), (i >= 3), 1'b0);
      end
      for (int i = 0; i < 60 && !empty_o; i++) begin
         expect_eq("stream.tail", int'(read_data_o), 8'h40 + nxt);
         nxt++;
         step("streamdrain", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      end
      expect_eq("stream.total", nxt, 40);
      expect_eq("stream.count0", int'(count_o), 0);

      // Randomized traffic with phases biased towards filling and draining.
      for (int i = 0; i < 3000; i++) begin
         int wp;
         logic rn, rdy, ren, clr;
         wp  = ((i / 200) % 2 == 0) ? 80 : 30;
         rn  = ($urandom_range(0, 299) != 0);
         rdy = ($urandom_range(0, 99) < wp);
         ren = ($urandom_range(0, 99) < (110 - wp));
         clr = ($urandom_range(0, 15) == 0);
         step("rand", rn, rdy, 8'($urandom), ren, clr);
      end
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer placed directly downstream of the UART receiver. Captures each byte the receiver flags on its single-cycle `RxReady` strobe and holds it in a circular FIFO until the host logic pops it through a first-word-fall-through read port. Reports occupancy, full/empty status and a sticky overrun flag so bytes arriving faster than the host drains them are detected rather than silently lost.

## Interface
- `DATA_BITS`, default 8: byte width; must match the receiver's `DATA_BITS`.
- `DEPTH_LOG2`, default 4: log2 of FIFO depth (16 entries); legal range 1..8.
- `Clock`  in  1: system clock (50 MHz); all state updates on its rising edge.
- `ResetN`  in  1: one clock; reset is synchronous and active-low.
- `RxReady`  in  1: write strobe from the receiver; each cycle high is one write request.
- `RxData`  in  DATA_BITS: byte from the receiver, sampled in cycles where `RxReady`=1.
- `ReadEn`  in  1: pop request from the consumer.
- `ClearOverrun`  in  1: clears the sticky `Overrun` flag.
- `ReadData`  out  DATA_BITS: head-of-FIFO byte, valid whenever `Empty`=0; forced to 0 when `Empty`=1.
- `Empty`  out  1: no stored bytes.
- `Full`  out  1: 2^DEPTH_LOG2 stored bytes.
- `Count`  out  DEPTH_LOG2+1: number of stored bytes, 0..2^DEPTH_LOG2.
- `Overrun`  out  1: sticky; set when a write is dropped because the FIFO is full.

## Operation
- Storage: 2^DEPTH_LOG2 × DATA_BITS register array. `WrPtr` and `RdPtr` are DEPTH_LOG2 bits wide and wrap modulo depth. `Count` is a separate DEPTH_LOG2+1-bit register.
- Accepted write = `RxReady` & (!`Full` | accepted read). Writes `RxData` to `mem[WrPtr]` and increments `WrPtr`.
- Accepted read = `ReadEn` & !`Empty`. Increments `RdPtr`; the popped byte is the `ReadData` value shown in that cycle.
- `Count` update:
  - Write only: +1.
  - Read only: −1.
  - Both, or neither: unchanged.
- Occupancy states (implicit FSM on `Count`): EMPTY (0), PARTIAL (1..depth−1), FULL (depth). Every transition is driven only by accepted reads and writes.
- Boundary rules:
  - Full and `RxReady`=1 with `ReadEn`=1: both accepted; stays FULL; no overrun.
  - Full and `RxReady`=1 with `ReadEn`=0: byte dropped; memory and pointers unchanged; `Overrun` set.
  - Empty and `ReadEn`=1 with `RxReady`=1: read ignored, write accepted; next cycle `Count`=1 and `ReadData`=new byte.
  - Empty and `ReadEn`=1 alone: no state change; no error flag.
  - `ClearOverrun`=1 in the same cycle as a new drop: set wins, so `Overrun` stays 1.
  - Pointer wrap: `WrPtr`/`RdPtr` = depth−1 → 0 with no loss of data.
- `ResetN`=0 at a clock edge, including mid-stream: `WrPtr`, `RdPtr` and `Count` go to 0 and `Overrun` goes to 0. Memory contents are not reset, and all stored bytes are discarded.
- `ResetN`=0 takes priority over all write, read and clear requests in the same cycle.

## Timing
- Reset values:
  - `Empty`=1, `Full`=0, `Count`=0, `Overrun`=0, `ReadData`=0.
- Write-to-read latency: a byte written at edge N appears on `ReadData` (if it is the head), `Empty`=0 and `Count` incremented immediately after edge N. It can be popped at edge N+1.
- `ReadData` is combinational from `mem[RdPtr]` gated by `Empty`. After a pop at edge N, the next byte is visible right after edge N.
- `Empty` and `Full` are decoded from the registered `Count`, with no extra latency.
- `Overrun` sets on the edge of the dropped write and clears on the edge where `ClearOverrun`=1 (when no drop occurs that cycle).
- Throughput: one write and one read per cycle sustained. The receiver supplies at most one byte per frame, so the FIFO never limits the line rate.

## Test plan
- Reset, then write 0x55 (one `RxReady` pulse) → next cycle `Empty`=0, `Count`=1, `ReadData`=0x55; `ReadEn` one cycle → `Empty`=1, `ReadData`=0.
- Write 16 bytes 0x00..0x0F with no reads → `Full`=1, `Count`=16. A 17th write of 0xAA → `Overrun`=1 and `Count` stays 16. Pop all 16 → data 0x00..0x0F in order, 0xAA never appears.
- While full, assert `RxReady` (0xC3) and `ReadEn` together → `Count` stays 16, `Overrun` stays 0, and 0xC3 is read last after the remaining 15 bytes.
- Stream 40 bytes with interleaved reads so the pointers wrap twice → output sequence equals input sequence; `Count` returns to 0.
- With `Overrun`=1, assert `ClearOverrun` in the same cycle as another full-FIFO drop → `Overrun` stays 1; `ClearOverrun` alone next cycle → 0.
- Load 5 bytes, pulse `ResetN`=0 for one cycle while `RxReady`=1 → `Count`=0, `Empty`=1, `Overrun`=0, and the write in the reset cycle is not stored.
